// File: rtl/itch_msg_assembler.sv
// Rebuilds length-prefixed order-book messages (2-byte big-endian length, then body) from a
// non-stallable byte stream and emits each as one left-aligned wide word with a valid pulse.
module itch_msg_assembler #(
    parameter int MAX_MSG_BYTES = 64,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                       clkIn,
    input  logic                       rstIn,
    input  logic [7:0]                 dataIn,
    input  logic                       dataValidIn,
    input  logic                       dataErrIn,
    output logic [MAX_MSG_BYTES*8-1:0] msgDataOut,
    output logic [LEN_WIDTH-1:0]       msgLenOut,
    output logic [7:0]                 msgTypeOut,
    output logic                       msgValidOut,
    output logic                       msgErrOut,
    output logic [31:0]                msgCntOut,
    output logic [15:0]                dropCntOut
);

    localparam int DATA_W = MAX_MSG_BYTES * 8;
    localparam int IDX_W  = $clog2(MAX_MSG_BYTES + 1);

    typedef enum logic [1:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_BODY,
        ST_DISCARD
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             len_hi_q, len_hi_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0]      buf_q, buf_d;
    logic [DATA_W-1:0]      msg_data_q, msg_data_d;
    logic [LEN_WIDTH-1:0]   msg_len_q, msg_len_d;
    logic [7:0]             msg_type_q, msg_type_d;
    logic                   msg_valid_q, msg_valid_d;
    logic                   msg_err_q, msg_err_d;
    logic [31:0]            msg_cnt_q, msg_cnt_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic                   body_wr;
    logic [DATA_W-1:0]      buf_wr;
    logic [LEN_WIDTH-1:0]   len_in;

    assign body_wr = (state_q == ST_BODY) && dataValidIn && !dataErrIn;
    assign len_in  = LEN_WIDTH'({len_hi_q, dataIn});

    // Buffer image including the byte arriving this cycle, so the last byte can be
    // forwarded straight into the output register.
    generate
        for (genvar gi = 0; gi < MAX_MSG_BYTES; gi++) begin : g_lane
            assign buf_wr[DATA_W-1-gi*8 -: 8] =
                (body_wr && (idx_q == IDX_W'(gi))) ? dataIn : buf_q[DATA_W-1-gi*8 -: 8];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        buf_d       = buf_q;
        msg_data_d  = msg_data_q;
        msg_len_d   = msg_len_q;
        msg_type_d  = msg_type_q;
        msg_valid_d = 1'b0;
        msg_err_d   = 1'b0;
        msg_cnt_d   = msg_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (dataErrIn) begin
            msg_err_d = 1'b1;
            state_d   = ST_LEN_HI;
        end else if (dataValidIn) begin
            case (state_q)
                ST_LEN_HI: begin
                    len_hi_d = dataIn;
                    state_d  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d = len_in;
                    idx_d = '0;
                    if (len_in == '0) begin
                        msg_err_d = 1'b1;
                        state_d   = ST_LEN_HI;
                    end else if (len_in > LEN_WIDTH'(MAX_MSG_BYTES)) begin
                        remaining_d = len_in;
                        state_d     = ST_DISCARD;
                    end else begin
                        buf_d   = '0;
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    buf_d = buf_wr;
                    idx_d = idx_q + IDX_W'(1);
                    if (LEN_WIDTH'(idx_q) == len_q - LEN_WIDTH'(1)) begin
                        msg_data_d  = buf_wr;
                        msg_len_d   = len_q;
                        msg_type_d  = buf_wr[DATA_W-1 -: 8];
                        msg_valid_d = 1'b1;
                        state_d     = ST_LEN_HI;
                    end
                end
                ST_DISCARD: begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        msg_err_d = 1'b1;
                        state_d   = ST_LEN_HI;
                    end
                end
                default: state_d = ST_LEN_HI;
            endcase
        end

        if (msg_valid_d) begin
            msg_cnt_d = msg_cnt_q + 32'd1;
        end
        if (msg_err_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q     <= ST_LEN_HI;
            len_hi_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            remaining_q <= '0;
            buf_q       <= '0;
            msg_data_q  <= '0;
            msg_len_q   <= '0;
            msg_type_q  <= '0;
            msg_valid_q <= 1'b0;
            msg_err_q   <= 1'b0;
            msg_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            buf_q       <= buf_d;
            msg_data_q  <= msg_data_d;
            msg_len_q   <= msg_len_d;
            msg_type_q  <= msg_type_d;
            msg_valid_q <= msg_valid_d;
            msg_err_q   <= msg_err_d;
            msg_cnt_q   <= msg_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign msgDataOut  = msg_data_q;
    assign msgLenOut   = msg_len_q;
    assign msgTypeOut  = msg_type_q;
    assign msgValidOut = msg_valid_q;
    assign msgErrOut   = msg_err_q;
    assign msgCntOut   = msg_cnt_q;
    assign dropCntOut  = drop_cnt_q;

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Directed and randomized byte streams for itch_msg_assembler, compared every cycle against
// a queue-based message parser that models the expected outputs.
module tb_itch_msg_assembler;

    localparam int MAXB   = 64;
    localparam int LW     = 16;
    localparam int DATA_W = MAXB * 8;

    logic              clkIn = 1'b0;
    logic              rstIn = 1'b1;
    logic [7:0]        dataIn = 8'h00;
    logic              dataValidIn = 1'b0;
    logic              dataErrIn = 1'b0;
    logic [DATA_W-1:0] msgDataOut;
    logic [LW-1:0]     msgLenOut;
    logic [7:0]        msgTypeOut;
    logic              msgValidOut;
    logic              msgErrOut;
    logic [31:0]       msgCntOut;
    logic [15:0]       dropCntOut;

    itch_msg_assembler #(.MAX_MSG_BYTES(MAXB), .LEN_WIDTH(LW)) dut (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .dataIn     (dataIn),
        .dataValidIn(dataValidIn),
        .dataErrIn  (dataErrIn),
        .msgDataOut (msgDataOut),
        .msgLenOut  (msgLenOut),
        .msgTypeOut (msgTypeOut),
        .msgValidOut(msgValidOut),
        .msgErrOut  (msgErrOut),
        .msgCntOut  (msgCntOut),
        .dropCntOut (dropCntOut)
    );

    always #2 clkIn = ~clkIn;

    int checks = 0;
    int failures = 0;

    // Reference: bytes of the message in flight (length prefix included).
    logic [7:0]        cur[$];
    logic [DATA_W-1:0] exp_data;
    logic [LW-1:0]     exp_len;
    logic [7:0]        exp_type;
    logic              exp_valid;
    logic              exp_err;
    logic [31:0]       exp_cnt;
    logic [15:0]       exp_drop;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cur.delete();
        exp_data  = '0;
        exp_len   = '0;
        exp_type  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_cnt   = '0;
        exp_drop  = '0;
    endtask

    task automatic model_step(input logic v, input logic e, input logic [7:0] d);
        int len;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (e) begin
            exp_err = 1'b1;
            cur.delete();
        end else if (v) begin
            cur.push_back(d);
            if (cur.size() >= 2) begin
                len = {cur[0], cur[1]};
                if (len == 0) begin
                    exp_err = 1'b1;
                    cur.delete();
                end else if (cur.size() == len + 2) begin
                    if (len > MAXB) begin
                        exp_err = 1'b1;
                    end else begin
                        exp_valid = 1'b1;
                        exp_data  = '0;
                        for (int i = 0; i < len; i++) exp_data[DATA_W-1-8*i -: 8] = cur[2+i];
                        exp_len   = LW'(len);
                        exp_type  = cur[2];
                    end
                    cur.delete();
                end
            end
        end
        if (exp_valid) exp_cnt = exp_cnt + 32'd1;
        if (exp_err && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    endtask

    task automatic step(input logic v, input logic e, input logic [7:0] d, input logic r);
        dataValidIn = v;
        dataErrIn   = e;
        dataIn      = d;
        rstIn       = r;
        @(posedge clkIn);
        if (r) model_reset();
        else   model_step(v, e, d);
        #1;
        chk("valid", DATA_W'(msgValidOut), DATA_W'(exp_valid));
        chk("err",   DATA_W'(msgErrOut),   DATA_W'(exp_err));
        chk("cnt",   DATA_W'(msgCntOut),   DATA_W'(exp_cnt));
        chk("drop",  DATA_W'(dropCntOut),  DATA_W'(exp_drop));
        chk("len",   DATA_W'(msgLenOut),   DATA_W'(exp_len));
        chk("type",  DATA_W'(msgTypeOut),  DATA_W'(exp_type));
        chk("data",  msgDataOut,           exp_data);
        dataValidIn = 1'b0;
        dataErrIn   = 1'b0;
    endtask

    task automatic put(input logic [7:0] d, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 8'h00, 1'b0);
        end
        step(1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_msg(input int len, input bit gaps, input bit allow_err);
        put(8'(len >> 8), gaps);
        put(8'(len), gaps);
        for (int i = 0; i < len; i++) begin
            if (allow_err && $urandom_range(0, 40) == 0) begin
                step(1'b0, 1'b1, 8'($urandom), 1'b0);
                return;
            end
            put(8'($urandom), gaps);
        end
    endtask

    initial begin
        model_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        chk("rst_cnt", DATA_W'(msgCntOut), '0);

        // single 3-byte message
        put(8'h00, 0); put(8'h03, 0); put(8'h41, 0); put(8'h42, 0); put(8'h43, 0);
        chk("t1_top24", DATA_W'(msgDataOut[DATA_W-1 -: 24]), DATA_W'(24'h414243));
        chk("t1_cnt", DATA_W'(msgCntOut), DATA_W'(32'd1));
        idle(2);

        // back-to-back
        put(8'h00, 0); put(8'h01, 0); put(8'hAA, 0);
        put(8'h00, 0); put(8'h02, 0); put(8'hBB, 0); put(8'hCC, 0);
        idle(2);

        // oversize dropped, then good message
        put(8'h00, 0); put(8'h41, 0);
        for (int i = 0; i < 65; i++) put(8'(i), 0);
        chk("t3_drop", DATA_W'(dropCntOut), DATA_W'(16'd1));
        put(8'h00, 0); put(8'h01, 0); put(8'h55, 0);
        chk("t3_type", DATA_W'(msgTypeOut), DATA_W'(8'h55));

        // abort via error input
        put(8'h00, 0); put(8'h04, 0); put(8'h11, 0); put(8'h22, 0);
        step(1'b1, 1'b1, 8'h33, 1'b0);
        put(8'h00, 0); put(8'h01, 0); put(8'h77, 0);
        chk("t4_type", DATA_W'(msgTypeOut), DATA_W'(8'h77));
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // zero length, then gapped messages
        put(8'h00, 0); put(8'h00, 0);
        send_msg(5, 1, 0);
        send_msg(64, 1, 0);
        send_msg(1, 1, 0);

        // reset mid-body
        put(8'h00, 0); put(8'h05, 0); put(8'h01, 0); put(8'h02, 0);
        step(1'b1, 1'b0, 8'h03, 1'b1);
        chk("t6_rst_data", msgDataOut, '0);
        put(8'h00, 0); put(8'h01, 0); put(8'h99, 0);
        chk("t6_cnt", DATA_W'(msgCntOut), DATA_W'(32'd1));

        // randomized traffic
        for (int m = 0; m < 150; m++) begin
            int sel;
            int len;
            sel = $urandom_range(0, 9);
            if (sel == 0)      len = 0;
            else if (sel == 1) len = $urandom_range(65, 72);
            else               len = $urandom_range(1, 64);
            send_msg(len, ($urandom_range(0, 1) == 1), 1);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
